// File: rtl/sdp_erdma_cq_rd.sv
// sdp_erdma_cq_rd
//   Egress-side consumer of the ERDMA context queue. Each popped 16-bit
//   context entry describes one DMA read request: beat count (minus one),
//   an end-of-surface flag and a tag. The matching read-response beats are
//   counted, tagged first/last/eos and forwarded through a registered
//   output stage.
// Ports:
//   nvdla_core_clk_mgated / nvdla_core_rstn : clock, async active-low reset
//   op_en                                   : layer enable, gates new pops
//   cq2eg_pvld/prdy/pd                      : context entry handshake
//   dma_rd_rsp_pvld/prdy/pd                 : DMA read-response beats
//   eg_out_pvld/prdy/pd, first/last/eos/tag : framed output beats
//   eg_done                                 : pulse after eos last beat leaves
//   eg_beat_cnt                             : wrapping count of output beats
module sdp_erdma_cq_rd #(
  parameter int DW   = 64,
  parameter int LENW = 4
) (
  input  logic                nvdla_core_clk_mgated,
  input  logic                nvdla_core_rstn,
  input  logic                op_en,
  input  logic                cq2eg_pvld,
  output logic                cq2eg_prdy,
  input  logic [15:0]         cq2eg_pd,
  input  logic                dma_rd_rsp_pvld,
  output logic                dma_rd_rsp_prdy,
  input  logic [DW-1:0]       dma_rd_rsp_pd,
  output logic                eg_out_pvld,
  input  logic                eg_out_prdy,
  output logic [DW-1:0]       eg_out_pd,
  output logic                eg_out_first,
  output logic                eg_out_last,
  output logic                eg_out_eos,
  output logic [14-LENW:0]    eg_out_tag,
  output logic                eg_done,
  output logic [31:0]         eg_beat_cnt
);

  localparam int TW = 15 - LENW;

  typedef enum logic {
    CTX_EMPTY  = 1'b0,
    CTX_ACTIVE = 1'b1
  } ctx_state_e;

  ctx_state_e       ctx_state_q, ctx_state_d;
  logic [LENW-1:0]  len_m1_q, len_m1_d;
  logic             eos_q, eos_d;
  logic [TW-1:0]    tag_q, tag_d;
  logic [LENW-1:0]  beat_idx_q, beat_idx_d;

  logic             out_pvld_q, out_pvld_d;
  logic [DW-1:0]    out_pd_q, out_pd_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;
  logic             out_eos_q, out_eos_d;
  logic [TW-1:0]    out_tag_q, out_tag_d;
  logic             done_q, done_d;
  logic [31:0]      beat_cnt_q, beat_cnt_d;

  logic ctx_vld;
  logic out_free;
  logic rsp_prdy;
  logic rsp_acc;
  logic rsp_acc_last;
  logic ld_ok;
  logic pop;
  logic out_hs;

  // Handshake qualifiers. rsp_prdy depends only on state and eg_out_prdy,
  // never on dma_rd_rsp_pvld.
  always_comb begin
    ctx_vld      = (ctx_state_q == CTX_ACTIVE);
    out_free     = !out_pvld_q || eg_out_prdy;
    rsp_prdy     = ctx_vld && out_free;
    rsp_acc      = dma_rd_rsp_pvld && rsp_prdy;
    rsp_acc_last = rsp_acc && (beat_idx_q == len_m1_q);
    // A new context may load in the same cycle the current one finishes,
    // so back-to-back requests have no bubble.
    ld_ok        = op_en && (!ctx_vld || rsp_acc_last);
    pop          = cq2eg_pvld && ld_ok;
    out_hs       = out_pvld_q && eg_out_prdy;
  end

  // Context register FSM: next state and loaded fields.
  always_comb begin
    ctx_state_d = ctx_state_q;
    len_m1_d    = len_m1_q;
    eos_d       = eos_q;
    tag_d       = tag_q;
    beat_idx_d  = beat_idx_q;

    if (rsp_acc) begin
      beat_idx_d = rsp_acc_last ? '0 : beat_idx_q + LENW'(1);
    end

    case (ctx_state_q)
      CTX_EMPTY: begin
        if (pop) begin
          ctx_state_d = CTX_ACTIVE;
        end
      end
      CTX_ACTIVE: begin
        if (rsp_acc_last && !pop) begin
          ctx_state_d = CTX_EMPTY;
        end
      end
      default: ctx_state_d = CTX_EMPTY;
    endcase

    if (pop) begin
      len_m1_d   = cq2eg_pd[LENW-1:0];
      eos_d      = cq2eg_pd[LENW];
      tag_d      = cq2eg_pd[15:LENW+1];
      beat_idx_d = '0;
    end
  end

  // Output stage: loads on an accepted beat, holds while stalled,
  // drains when free and nothing new arrives.
  always_comb begin
    out_pvld_d  = out_pvld_q;
    out_pd_d    = out_pd_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_eos_d   = out_eos_q;
    out_tag_d   = out_tag_q;
    done_d      = out_hs && out_eos_q;
    beat_cnt_d  = out_hs ? beat_cnt_q + 32'd1 : beat_cnt_q;

    if (rsp_acc) begin
      out_pvld_d  = 1'b1;
      out_pd_d    = dma_rd_rsp_pd;
      out_first_d = (beat_idx_q == '0);
      out_last_d  = rsp_acc_last;
      out_eos_d   = rsp_acc_last && eos_q;
      out_tag_d   = tag_q;
    end else if (out_free) begin
      out_pvld_d  = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      ctx_state_q <= CTX_EMPTY;
      len_m1_q    <= '0;
      eos_q       <= 1'b0;
      tag_q       <= '0;
      beat_idx_q  <= '0;
      out_pvld_q  <= 1'b0;
      out_pd_q    <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_eos_q   <= 1'b0;
      out_tag_q   <= '0;
      done_q      <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      ctx_state_q <= ctx_state_d;
      len_m1_q    <= len_m1_d;
      eos_q       <= eos_d;
      tag_q       <= tag_d;
      beat_idx_q  <= beat_idx_d;
      out_pvld_q  <= out_pvld_d;
      out_pd_q    <= out_pd_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_eos_q   <= out_eos_d;
      out_tag_q   <= out_tag_d;
      done_q      <= done_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign cq2eg_prdy      = ld_ok;
  assign dma_rd_rsp_prdy = rsp_prdy;
  assign eg_out_pvld     = out_pvld_q;
  assign eg_out_pd       = out_pd_q;
  assign eg_out_first    = out_first_q;
  assign eg_out_last     = out_last_q;
  assign eg_out_eos      = out_eos_q;
  assign eg_out_tag      = out_tag_q;
  assign eg_done         = done_q;
  assign eg_beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_sdp_erdma_cq_rd.sv
module tb_sdp_erdma_cq_rd;

  logic        clk = 1'b0;
  logic        rstn;
  logic        op_en;
  logic        cq_pvld;
  logic        cq_prdy;
  logic [15:0] cq_pd;
  logic        rsp_pvld;
  logic        rsp_prdy;
  logic [63:0] rsp_pd;
  logic        out_pvld;
  logic        out_prdy;
  logic [63:0] out_pd;
  logic        out_first, out_last, out_eos;
  logic [10:0] out_tag;
  logic        done;
  logic [31:0] beat_cnt;

  always #5 clk = ~clk;

  sdp_erdma_cq_rd #(.DW(64), .LENW(4)) dut (
    .nvdla_core_clk_mgated (clk),
    .nvdla_core_rstn       (rstn),
    .op_en                 (op_en),
    .cq2eg_pvld            (cq_pvld),
    .cq2eg_prdy            (cq_prdy),
    .cq2eg_pd              (cq_pd),
    .dma_rd_rsp_pvld       (rsp_pvld),
    .dma_rd_rsp_prdy       (rsp_prdy),
    .dma_rd_rsp_pd         (rsp_pd),
    .eg_out_pvld           (out_pvld),
    .eg_out_prdy           (out_prdy),
    .eg_out_pd             (out_pd),
    .eg_out_first          (out_first),
    .eg_out_last           (out_last),
    .eg_out_eos            (out_eos),
    .eg_out_tag            (out_tag),
    .eg_done               (done),
    .eg_beat_cnt           (beat_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one active request described by its entry fields and
  // the number of beats already consumed; output beats queued in order.
  typedef struct {
    logic [63:0] pd;
    logic        first;
    logic        last;
    logic        eos;
    logic [10:0] tag;
  } beat_t;

  beat_t       oq[$];
  logic        m_active;
  int          m_len;
  int          m_done_beats;
  logic        m_eos;
  logic [10:0] m_tag;
  logic        m_done_next;
  int          m_cnt;
  int          done_pulses = 0;
  logic        cq_hs_seen = 1'b0;
  logic        rsp_hs_seen = 1'b0;

  task automatic model_reset();
    oq.delete();
    m_active     = 1'b0;
    m_len        = 0;
    m_done_beats = 0;
    m_eos        = 1'b0;
    m_tag        = '0;
    m_done_next  = 1'b0;
    m_cnt        = 0;
  endtask

  initial model_reset();

  // Sampled on the falling edge: inputs and DUT outputs are settled and
  // describe exactly what happens at the next rising edge.
  always @(negedge clk) begin
    logic  exp_rsp_prdy, exp_cq_prdy, hs_rsp, hs_out, last, pop;
    beat_t b;
    cq_hs_seen  = cq_pvld && cq_prdy;
    rsp_hs_seen = rsp_pvld && rsp_prdy;
    if (done) done_pulses++;
    if (!rstn) begin
      model_reset();
      chk("rst_out_pvld", out_pvld, 0);
      chk("rst_out_pd", out_pd, 0);
      chk("rst_flags", {out_first, out_last, out_eos}, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_done", done, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_rsp_prdy", rsp_prdy, 0);
    end else begin
      chk("beat_cnt", beat_cnt, m_cnt);
      chk("eg_done", done, m_done_next);
      chk("out_pvld", out_pvld, oq.size() != 0);
      if (oq.size() != 0) begin
        chk("out_pd", out_pd, oq[0].pd);
        chk("out_first", out_first, oq[0].first);
        chk("out_last", out_last, oq[0].last);
        chk("out_eos", out_eos, oq[0].eos);
        chk("out_tag", out_tag, oq[0].tag);
      end
      exp_rsp_prdy = m_active && (oq.size() == 0 || out_prdy);
      hs_rsp       = rsp_pvld && exp_rsp_prdy;
      last         = hs_rsp && (m_done_beats == m_len);
      exp_cq_prdy  = op_en && (!m_active || last);
      pop          = cq_pvld && exp_cq_prdy;
      chk("rsp_prdy", rsp_prdy, exp_rsp_prdy);
      chk("cq_prdy", cq_prdy, exp_cq_prdy);

      hs_out      = (oq.size() != 0) && out_prdy;
      m_done_next = hs_out && oq[0].eos;
      if (hs_out) begin
        void'(oq.pop_front());
        m_cnt++;
      end
      if (hs_rsp) begin
        b.pd    = rsp_pd;
        b.first = (m_done_beats == 0);
        b.last  = last;
        b.eos   = last && m_eos;
        b.tag   = m_tag;
        oq.push_back(b);
        m_done_beats++;
        if (last) m_active = 1'b0;
      end
      if (pop) begin
        m_active     = 1'b1;
        m_len        = int'(cq_pd[3:0]);
        m_eos        = cq_pd[4];
        m_tag        = cq_pd[15:5];
        m_done_beats = 0;
      end
    end
  end

  logic [63:0] seq = 64'hD000_0000_0000_0000;

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves cq_pvld asserted so the caller can chain entries without a gap.
  task automatic push_entry(input logic [15:0] e);
    cq_pvld = 1'b1;
    cq_pd   = e;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (cq_hs_seen) return;
    end
    chk("cq_pop_timeout", 1, 0);
  endtask

  task automatic send_beats(input int n);
    for (int k = 0; k < n; k++) begin
      logic ok;
      ok       = 1'b0;
      rsp_pvld = 1'b1;
      rsp_pd   = seq;
      seq      = seq + 64'h1_0001;
      for (int i = 0; i < 300 && !ok; i++) begin
        @(posedge clk);
        #1;
        if (rsp_hs_seen) ok = 1'b1;
      end
      if (!ok) chk("rsp_accept_timeout", 1, 0);
    end
    rsp_pvld = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    op_en    = 1'b0;
    cq_pvld  = 1'b0;
    cq_pd    = '0;
    rsp_pvld = 1'b0;
    rsp_pd   = '0;
    out_prdy = 1'b1;
    cycles(3);
    rstn  = 1'b1;
    op_en = 1'b1;
    cycles(2);
    chk("lit_idle_cnt", beat_cnt, 0);
    chk("lit_idle_rsp_prdy", rsp_prdy, 0);

    // 4-beat request, tag 0x12
    fork
      begin push_entry({11'h012, 1'b0, 4'd3}); cq_pvld = 1'b0; end
      send_beats(4);
    join
    cycles(3);
    chk("lit_t1_cnt", beat_cnt, 4);

    // two requests chained: 2 beats, then 1-beat eos request
    fork
      begin
        push_entry({11'h055, 1'b0, 4'd1});
        push_entry({11'h7A5, 1'b1, 4'd0});
        cq_pvld = 1'b0;
      end
      send_beats(3);
    join
    cycles(3);
    chk("lit_t2_cnt", beat_cnt, 7);
    chk("lit_t2_done_pulses", done_pulses, 1);

    // downstream stall of 5 cycles mid-request
    fork
      begin push_entry({11'h3C3, 1'b0, 4'd7}); cq_pvld = 1'b0; end
      send_beats(8);
      begin
        cycles(4);
        out_prdy = 1'b0;
        cycles(3);
        chk("lit_t3_stall_rsp_prdy", rsp_prdy, 0);
        chk("lit_t3_stall_pvld", out_pvld, 1);
        cycles(2);
        out_prdy = 1'b1;
      end
    join
    cycles(3);
    chk("lit_t3_cnt", beat_cnt, 15);

    // beats waiting with no context are stalled until an entry arrives
    fork
      send_beats(2);
      begin
        cycles(6);
        chk("lit_t4_no_ctx_prdy", rsp_prdy, 0);
        push_entry({11'h001, 1'b0, 4'd1});
        cq_pvld = 1'b0;
      end
    join
    cycles(3);
    chk("lit_t4_cnt", beat_cnt, 17);

    // op_en low blocks pops; dropping it mid-request lets the request finish
    op_en = 1'b0;
    cq_pvld = 1'b1;
    cq_pd   = {11'h111, 1'b0, 4'd15};
    cycles(4);
    chk("lit_t5_op_off_prdy", cq_prdy, 0);
    op_en = 1'b1;
    fork
      begin
        push_entry({11'h111, 1'b0, 4'd15});
        cq_pd = {11'h222, 1'b1, 4'd2};
        cycles(4);
        op_en = 1'b0;
      end
      send_beats(16);
    join
    cycles(5);
    chk("lit_t5_cnt", beat_cnt, 33);
    chk("lit_t5_no_pop_prdy", cq_prdy, 0);
    cq_pvld = 1'b0;
    op_en   = 1'b1;
    chk("lit_t5_done_pulses", done_pulses, 1);

    // async reset after two of four beats
    fork
      begin push_entry({11'h0AB, 1'b0, 4'd3}); cq_pvld = 1'b0; end
      send_beats(2);
    join
    rsp_pvld = 1'b1;
    rsp_pd   = seq;
    #2;
    rstn = 1'b0;
    #1;
    chk("lit_t6_rst_pvld", out_pvld, 0);
    chk("lit_t6_rst_cnt", beat_cnt, 0);
    chk("lit_t6_rst_rsp_prdy", rsp_prdy, 0);
    chk("lit_t6_rst_pd", out_pd, 0);
    rsp_pvld = 1'b0;
    cycles(2);
    rstn = 1'b1;
    cycles(2);
    fork
      begin push_entry({11'h0CD, 1'b0, 4'd3}); cq_pvld = 1'b0; end
      send_beats(4);
    join
    cycles(3);
    chk("lit_t6_cnt", beat_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
